apb_master_bridge: RTL

Single-outstanding APB4 requester that turns a valid/ready command into a complete APB SETUP/ACCESS transfer and returns the result on a valid/ready response channel. It drives the master side of the team's APB bus: PADDR/PPROT/PSEL/PENABLE/PWRITE/PWDATA/PSTRB out, PREADY/PRDATA/PSLVERR in. Test sequences and on-chip control logic use it to reach the APB FIFO/register slave. A wait-state timeout guarantees that every accepted command produces exactly one response.

---
 rtl/apb_master_bridge.sv | 122 ++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// Purpose : single-outstanding APB4 requester; one valid/ready command in, one SETUP/ACCESS transfer, one response out.
// Latency : cmd accept at edge T -> SETUP T..T+1 -> ACCESS from T+1 -> rsp_valid from T+2 plus one cycle per wait state.
// Backpr. : cmd_ready low from accept until the response is consumed; the response is held until rsp_ready.
//
// Ports:
//   PCLK, PRESET               clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_write/addr/wdata/strb/prot carry the command
//   rsp_valid/rsp_ready        response handshake; rsp_rdata/rsp_err/rsp_timeout carry the result
//   PADDR..PSTRB               APB requester outputs (all registered)
//   PREADY/PRDATA/PSLVERR      APB completer inputs
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_strb,
   input  logic [2:0]            cmd_prot,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_W-1:0]     PADDR,
   output logic [2:0]            PPROT,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_W-1:0]     PWDATA,
   output logic [DATA_W/8-1:0]   PSTRB,
   input  logic                  PREADY,
   input  logic [DATA_W-1:0]     PRDATA,
   input  logic                  PSLVERR
);

   localparam bit             TO_EN = (TIMEOUT > 0);
   localparam int             CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         cmd_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         PADDR       <= '0;
         PPROT       <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PWDATA      <= '0;
         PSTRB       <= '0;
      end else begin
         case (state)
            IDLE: begin
               // cmd_ready is only ever low in IDLE for the first cycle after reset
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  PADDR     <= cmd_addr;
                  PPROT     <= cmd_prot;
                  PWRITE    <= cmd_write;
                  PWDATA    <= cmd_write ? cmd_wdata : '0;
                  PSTRB     <= cmd_write ? cmd_strb  : '0;
                  PSEL      <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               PENABLE  <= 1'b1;
               wait_cnt <= '0;
               state    <= ACCESS;
            end
            ACCESS: begin
               // PREADY is checked first so a completion on the limit cycle wins over the abort
               if (PREADY) begin
                  rsp_rdata   <= PWRITE ? '0 : PRDATA;
                  rsp_err     <= PSLVERR;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  state       <= RESP;
               end else if (TO_EN && (wait_cnt == LIMIT)) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
